// File: rtl/memrw_split_if.sv
// Request, data-memory and result signals of the memrw_split load/store stage.
// slave is the stage's view; master is the view of whoever drives it.
interface memrw_split_if #(
  parameter int NUM_HART       = 4,
  parameter int REG_WIDTH      = 32,
  parameter int MEM_ADDR_WIDTH = 32
);
  localparam int BYTES_PER_REG = REG_WIDTH / 8;

  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_HART-1:0]       in_hart_sel;
  logic                      in_rd_en;
  logic                      in_wr_en;
  logic [MEM_ADDR_WIDTH-1:0] in_addr;
  logic [REG_WIDTH-1:0]      in_wr_data;
  logic [1:0]                in_size;
  logic                      in_sign_ext;

  logic [MEM_ADDR_WIDTH-1:0] dmem_addr;
  logic                      dmem_rd_en;
  logic                      dmem_wr_en;
  logic [REG_WIDTH-1:0]      dmem_wr_data;
  logic [BYTES_PER_REG-1:0]  dmem_wr_ben;
  logic                      dmem_rd_ack;
  logic [REG_WIDTH-1:0]      dmem_rd_data;
  logic                      dmem_wr_ack;

  logic                      out_valid;
  logic [NUM_HART-1:0]       out_hart_sel;
  logic [REG_WIDTH-1:0]      out_rd_data;
  logic                      out_fault;

  modport slave (
    input  in_valid, in_hart_sel, in_rd_en, in_wr_en, in_addr, in_wr_data, in_size, in_sign_ext,
           dmem_rd_ack, dmem_rd_data, dmem_wr_ack,
    output in_ready, dmem_addr, dmem_rd_en, dmem_wr_en, dmem_wr_data, dmem_wr_ben,
           out_valid, out_hart_sel, out_rd_data, out_fault
  );

  modport master (
    output in_valid, in_hart_sel, in_rd_en, in_wr_en, in_addr, in_wr_data, in_size, in_sign_ext,
           dmem_rd_ack, dmem_rd_data, dmem_wr_ack,
    input  in_ready, dmem_addr, dmem_rd_en, dmem_wr_en, dmem_wr_data, dmem_wr_ben,
           out_valid, out_hart_sel, out_rd_data, out_fault
  );
endinterface

// File: rtl/memrw_split.sv
// Registered multi-cycle load/store stage: splits word-crossing accesses into two
// aligned beats, aligns/extends load data and turns bus timeouts into hart-tagged faults.
module memrw_split #(
  parameter int NUM_HART       = 4,
  parameter int REG_WIDTH      = 32,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int WAIT_LIMIT     = 255
) (
  input logic         clk,
  input logic         rst,
  memrw_split_if.slave bus
);
  localparam int BYTES_PER_REG = REG_WIDTH / 8;
  localparam int OFF_W         = $clog2(BYTES_PER_REG);
  localparam int CNT_W         = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t state, state_n;

  logic [NUM_HART-1:0]       hart_q, hart_n;
  logic                      rd_q, rd_n, wr_q, wr_n;
  logic                      sext_q, sext_n, split_q, split_n;
  logic [1:0]                size_q, size_n;
  logic [OFF_W-1:0]          off_q, off_n;
  logic [REG_WIDTH-1:0]      lo_q, lo_n;
  logic [REG_WIDTH-1:0]      wdata_hi_q, wdata_hi_n;
  logic [BYTES_PER_REG-1:0]  ben_hi_q, ben_hi_n;
  logic [CNT_W-1:0]          cnt_q, cnt_n;

  logic [MEM_ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_n;
  logic                      dmem_rd_en_q, dmem_rd_en_n;
  logic                      dmem_wr_en_q, dmem_wr_en_n;
  logic [REG_WIDTH-1:0]      dmem_wr_data_q, dmem_wr_data_n;
  logic [BYTES_PER_REG-1:0]  dmem_wr_ben_q, dmem_wr_ben_n;
  logic                      out_valid_q, out_valid_n;
  logic [NUM_HART-1:0]       out_hart_q, out_hart_n;
  logic [REG_WIDTH-1:0]      out_data_q, out_data_n;
  logic                      out_fault_q, out_fault_n;

  logic                       accept, beat_ack, in_split, in_illegal;
  logic [OFF_W-1:0]           in_off;
  logic [2*BYTES_PER_REG-1:0] in_ben_wide;
  logic [2*REG_WIDTH-1:0]     in_data_wide;
  logic [REG_WIDTH-1:0]       lo_v, hi_v, ld_shift, ld_mask, ld_result;
  logic                       ld_sign;

  assign accept   = bus.in_valid && (state == IDLE);
  assign beat_ack = (rd_q && bus.dmem_rd_ack) || (wr_q && bus.dmem_wr_ack);

  // Both beats' lanes come from one double-width shift; the upper half is beat 1.
  assign in_off       = bus.in_addr[OFF_W-1:0];
  assign in_split     = (32'(in_off) + (32'd1 << bus.in_size)) > 32'(BYTES_PER_REG);
  assign in_illegal   = (bus.in_rd_en && bus.in_wr_en) || ((32'd8 << bus.in_size) > 32'(REG_WIDTH));
  assign in_ben_wide  = (2*BYTES_PER_REG)'((1 << (1 << bus.in_size)) - 1) << in_off;
  assign in_data_wide = {{REG_WIDTH{1'b0}}, bus.in_wr_data} << {in_off, 3'b000};

  // The final beat's read word is used directly so the result is ready on the ack edge.
  assign lo_v      = (state == BEAT0) ? bus.dmem_rd_data : lo_q;
  assign hi_v      = (state == BEAT1) ? bus.dmem_rd_data : '0;
  assign ld_shift  = REG_WIDTH'({hi_v, lo_v} >> {off_q, 3'b000});
  assign ld_mask   = {REG_WIDTH{1'b1}} >> (32'(REG_WIDTH) - (32'd8 << size_q));
  assign ld_sign   = sext_q && |(ld_shift & (ld_mask ^ (ld_mask >> 1)));
  assign ld_result = ld_sign ? (ld_shift | ~ld_mask) : (ld_shift & ld_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      hart_q         <= '0;
      rd_q           <= 1'b0;
      wr_q           <= 1'b0;
      sext_q         <= 1'b0;
      split_q        <= 1'b0;
      size_q         <= '0;
      off_q          <= '0;
      lo_q           <= '0;
      wdata_hi_q     <= '0;
      ben_hi_q       <= '0;
      cnt_q          <= '0;
      dmem_addr_q    <= '0;
      dmem_rd_en_q   <= 1'b0;
      dmem_wr_en_q   <= 1'b0;
      dmem_wr_data_q <= '0;
      dmem_wr_ben_q  <= '0;
      out_valid_q    <= 1'b0;
      out_hart_q     <= '0;
      out_data_q     <= '0;
      out_fault_q    <= 1'b0;
    end else begin
      state          <= state_n;
      hart_q         <= hart_n;
      rd_q           <= rd_n;
      wr_q           <= wr_n;
      sext_q         <= sext_n;
      split_q        <= split_n;
      size_q         <= size_n;
      off_q          <= off_n;
      lo_q           <= lo_n;
      wdata_hi_q     <= wdata_hi_n;
      ben_hi_q       <= ben_hi_n;
      cnt_q          <= cnt_n;
      dmem_addr_q    <= dmem_addr_n;
      dmem_rd_en_q   <= dmem_rd_en_n;
      dmem_wr_en_q   <= dmem_wr_en_n;
      dmem_wr_data_q <= dmem_wr_data_n;
      dmem_wr_ben_q  <= dmem_wr_ben_n;
      out_valid_q    <= out_valid_n;
      out_hart_q     <= out_hart_n;
      out_data_q     <= out_data_n;
      out_fault_q    <= out_fault_n;
    end
  end

  always_comb begin
    state_n        = state;
    hart_n         = hart_q;
    rd_n           = rd_q;
    wr_n           = wr_q;
    sext_n         = sext_q;
    split_n        = split_q;
    size_n         = size_q;
    off_n          = off_q;
    lo_n           = lo_q;
    wdata_hi_n     = wdata_hi_q;
    ben_hi_n       = ben_hi_q;
    cnt_n          = cnt_q;
    dmem_addr_n    = dmem_addr_q;
    dmem_rd_en_n   = dmem_rd_en_q;
    dmem_wr_en_n   = dmem_wr_en_q;
    dmem_wr_data_n = dmem_wr_data_q;
    dmem_wr_ben_n  = dmem_wr_ben_q;
    out_valid_n    = 1'b0;
    out_hart_n     = out_hart_q;
    out_data_n     = out_data_q;
    out_fault_n    = out_fault_q;

    case (state)
      IDLE: begin
        if (accept) begin
          hart_n      = bus.in_hart_sel;
          rd_n        = bus.in_rd_en;
          wr_n        = bus.in_wr_en;
          sext_n      = bus.in_sign_ext;
          size_n      = bus.in_size;
          off_n       = in_off;
          split_n     = in_split;
          wdata_hi_n  = in_data_wide[2*REG_WIDTH-1:REG_WIDTH];
          ben_hi_n    = in_ben_wide[2*BYTES_PER_REG-1:BYTES_PER_REG];
          out_hart_n  = bus.in_hart_sel;
          out_data_n  = '0;
          out_fault_n = 1'b0;
          if (in_illegal) begin
            state_n     = DONE;
            out_valid_n = 1'b1;
            out_fault_n = 1'b1;
          end else if (!bus.in_rd_en && !bus.in_wr_en) begin
            state_n     = DONE;
            out_valid_n = 1'b1;
          end else begin
            state_n        = BEAT0;
            cnt_n          = '0;
            dmem_addr_n    = {bus.in_addr[MEM_ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            dmem_rd_en_n   = bus.in_rd_en;
            dmem_wr_en_n   = bus.in_wr_en;
            dmem_wr_data_n = in_data_wide[REG_WIDTH-1:0];
            dmem_wr_ben_n  = in_ben_wide[BYTES_PER_REG-1:0];
          end
        end
      end

      BEAT0, BEAT1: begin
        // A matching ack beats the timeout even on the limit cycle.
        if (beat_ack) begin
          if (state == BEAT0) begin
            lo_n = bus.dmem_rd_data;
          end
          if (state == BEAT0 && split_q) begin
            state_n        = BEAT1;
            cnt_n          = '0;
            dmem_addr_n    = dmem_addr_q + MEM_ADDR_WIDTH'(BYTES_PER_REG);
            dmem_wr_data_n = wdata_hi_q;
            dmem_wr_ben_n  = ben_hi_q;
          end else begin
            state_n        = DONE;
            out_valid_n    = 1'b1;
            out_data_n     = rd_q ? ld_result : '0;
            out_fault_n    = 1'b0;
            dmem_addr_n    = '0;
            dmem_rd_en_n   = 1'b0;
            dmem_wr_en_n   = 1'b0;
            dmem_wr_data_n = '0;
            dmem_wr_ben_n  = '0;
          end
        end else if (cnt_q == CNT_W'(WAIT_LIMIT - 1)) begin
          state_n        = DONE;
          out_valid_n    = 1'b1;
          out_data_n     = '0;
          out_fault_n    = 1'b1;
          dmem_addr_n    = '0;
          dmem_rd_en_n   = 1'b0;
          dmem_wr_en_n   = 1'b0;
          dmem_wr_data_n = '0;
          dmem_wr_ben_n  = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.dmem_addr    = dmem_addr_q;
  assign bus.dmem_rd_en   = dmem_rd_en_q;
  assign bus.dmem_wr_en   = dmem_wr_en_q;
  assign bus.dmem_wr_data = dmem_wr_data_q;
  assign bus.dmem_wr_ben  = dmem_wr_ben_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_hart_sel = out_hart_q;
  assign bus.out_rd_data  = out_data_q;
  assign bus.out_fault    = out_fault_q;
endmodule

// File: tb/tb_memrw_split.sv
// Directed vectors for memrw_split with a cycle-level dmem responder;
// a short timeout limit makes fault cases quick to reach.
module tb_memrw_split;
  localparam int NH = 4;
  localparam int RW = 32;
  localparam int AW = 32;
  localparam int WL = 4;
  localparam int NV = 15;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  memrw_split_if #(.NUM_HART(NH), .REG_WIDTH(RW), .MEM_ADDR_WIDTH(AW)) bus ();

  memrw_split #(.NUM_HART(NH), .REG_WIDTH(RW), .MEM_ADDR_WIDTH(AW), .WAIT_LIMIT(WL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // delay < 0 means the beat is never acked; wrong=1 pulses the other ack while waiting.
  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sext;
    logic [3:0]  hart;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic        wrong;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    int          beats;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [3:0]  ben0;
    logic [3:0]  ben1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [31:0] exp_data;
    logic        exp_fault;
    int          lat;
    int          en;
  } vec_t;

  vec_t vecs[NV];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int          c, w, beat_idx, beats_seen, en_cycles, lat;
    logic [31:0] seen_addr[2];
    logic [31:0] seen_wd[2];
    logic [3:0]  seen_ben[2];
    string       p;
    p = $sformatf("v%0d", idx);
    for (int k = 0; k < 2; k++) begin
      seen_addr[k] = '0;
      seen_wd[k]   = '0;
      seen_ben[k]  = '0;
    end
    checkOutput({p, "_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid    = 1'b1;
    bus.in_hart_sel = v.hart;
    bus.in_rd_en    = v.rd;
    bus.in_wr_en    = v.wr;
    bus.in_addr     = v.addr;
    bus.in_wr_data  = v.wdata;
    bus.in_size     = v.size;
    bus.in_sign_ext = v.sext;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    c = 1; w = 0; beat_idx = 0; beats_seen = 0; en_cycles = 0; lat = -1;
    while (c <= 20 && lat < 0) begin
      bus.dmem_rd_ack  = 1'b0;
      bus.dmem_wr_ack  = 1'b0;
      bus.dmem_rd_data = 32'hDEADBEEF;
      if (bus.out_valid) begin
        lat = c;
      end else begin
        if (bus.dmem_rd_en || bus.dmem_wr_en) begin
          en_cycles++;
          if (w == 0) begin
            if (beats_seen < 2) begin
              seen_addr[beats_seen] = bus.dmem_addr;
              seen_wd[beats_seen]   = bus.dmem_wr_data;
              seen_ben[beats_seen]  = bus.dmem_wr_ben;
            end
            beats_seen++;
            checkOutput($sformatf("%s_kind%0d", p, beats_seen), 64'({bus.dmem_rd_en, bus.dmem_wr_en}),
                        64'({v.rd, v.wr}));
          end
          if (v.delay >= 0 && w == v.delay) begin
            if (v.rd) begin
              bus.dmem_rd_ack  = 1'b1;
              bus.dmem_rd_data = (beat_idx == 0) ? v.rdata0 : v.rdata1;
            end else begin
              bus.dmem_wr_ack = 1'b1;
            end
            beat_idx++;
            w = 0;
          end else begin
            w++;
            if (v.wrong) begin
              if (v.rd) bus.dmem_wr_ack = 1'b1;
              else      bus.dmem_rd_ack = 1'b1;
            end
          end
        end
        @(posedge clk); #1;
        c++;
      end
    end
    checkOutput({p, "_lat"}, 64'(lat), 64'(v.lat));
    checkOutput({p, "_data"}, 64'(bus.out_rd_data), 64'(v.exp_data));
    checkOutput({p, "_fault"}, 64'(bus.out_fault), 64'(v.exp_fault));
    checkOutput({p, "_hart"}, 64'(bus.out_hart_sel), 64'(v.hart));
    checkOutput({p, "_done_en"}, 64'({bus.dmem_rd_en, bus.dmem_wr_en}), 64'd0);
    checkOutput({p, "_beats"}, 64'(beats_seen), 64'(v.beats));
    checkOutput({p, "_en_cycles"}, 64'(en_cycles), 64'(v.en));
    if (v.beats >= 1) checkOutput({p, "_addr0"}, 64'(seen_addr[0]), 64'(v.addr0));
    if (v.beats == 2) checkOutput({p, "_addr1"}, 64'(seen_addr[1]), 64'(v.addr1));
    if (v.wr && v.beats >= 1) begin
      checkOutput({p, "_ben0"}, 64'(seen_ben[0]), 64'(v.ben0));
      checkOutput({p, "_wd0"}, 64'(seen_wd[0]), 64'(v.wd0));
    end
    if (v.wr && v.beats == 2) begin
      checkOutput({p, "_ben1"}, 64'(seen_ben[1]), 64'(v.ben1));
      checkOutput({p, "_wd1"}, 64'(seen_wd[1]), 64'(v.wd1));
    end
    bus.dmem_rd_ack = 1'b0;
    bus.dmem_wr_ack = 1'b0;
    @(posedge clk); #1;
    checkOutput({p, "_pulse"}, 64'(bus.out_valid), 64'd0);
    checkOutput({p, "_ready_after"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    //          rd    wr    sz    sx    hart     addr           wdata          dly wr    rdata0         rdata1         bt addr0          addr1          ben0     ben1     wd0            wd1            data           flt   lat en
    vecs[0]  = '{1'b1, 1'b0, 2'd2, 1'b0, 4'b0001, 32'h00000100, 32'h00000000, 0, 1'b0, 32'h80FF1234, 32'h00000000, 1, 32'h00000100, 32'h00000000, 4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 32'h80FF1234, 1'b0, 2, 1};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b1, 4'b0010, 32'h00000103, 32'h00000000, 0, 1'b0, 32'h80FF1234, 32'h00000000, 1, 32'h00000100, 32'h00000000, 4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 32'hFFFFFF80, 1'b0, 2, 1};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 4'b0100, 32'h00000103, 32'h00000000, 0, 1'b0, 32'h80FF1234, 32'h00000000, 1, 32'h00000100, 32'h00000000, 4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000080, 1'b0, 2, 1};
    vecs[3]  = '{1'b0, 1'b1, 2'd2, 1'b0, 4'b1000, 32'h00000106, 32'hAABBCCDD, 2, 1'b0, 32'h00000000, 32'h00000000, 2, 32'h00000104, 32'h00000108, 4'b1100, 4'b0011, 32'hCCDD0000, 32'h0000AABB, 32'h00000000, 1'b0, 7, 6};
    vecs[4]  = '{1'b1, 1'b0, 2'd1, 1'b0, 4'b0001, 32'h000001FF, 32'h00000000, 0, 1'b0, 32'h11AABBCC, 32'hDDEEFF22, 2, 32'h000001FC, 32'h00000200, 4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 32'h00002211, 1'b0, 3, 2};
    vecs[5]  = '{1'b1, 1'b0, 2'd1, 1'b1, 4'b0010, 32'h000001FF, 32'h00000000, 0, 1'b0, 32'h80000000, 32'h000000FF, 2, 32'h000001FC, 32'h00000200, 4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 32'hFFFFFF80, 1'b0, 3, 2};
    vecs[6]  = '{1'b1, 1'b0, 2'd1, 1'b1, 4'b0100, 32'h00000102, 32'h00000000, 0, 1'b0, 32'h80010000, 32'h00000000, 1, 32'h00000100, 32'h00000000, 4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 32'hFFFF8001, 1'b0, 2, 1};
    vecs[7]  = '{1'b1, 1'b0, 2'd2, 1'b0, 4'b1000, 32'h00000040, 32'h00000000, -1, 1'b0, 32'h00000000, 32'h00000000, 1, 32'h00000040, 32'h00000000, 4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 5, 4};
    vecs[8]  = '{1'b1, 1'b0, 2'd2, 1'b0, 4'b0001, 32'h00000044, 32'h00000000, 3, 1'b0, 32'h12345678, 32'h00000000, 1, 32'h00000044, 32'h00000000, 4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 32'h12345678, 1'b0, 5, 4};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 1'b0, 4'b0010, 32'h00000201, 32'h000000A5, 1, 1'b1, 32'h00000000, 32'h00000000, 1, 32'h00000200, 32'h00000000, 4'b0010, 4'b0000, 32'h0000A500, 32'h00000000, 32'h00000000, 1'b0, 3, 2};
    vecs[10] = '{1'b1, 1'b1, 2'd2, 1'b0, 4'b0100, 32'h00000300, 32'h00000000, 0, 1'b0, 32'h00000000, 32'h00000000, 0, 32'h00000000, 32'h00000000, 4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1, 0};
    vecs[11] = '{1'b1, 1'b0, 2'd3, 1'b0, 4'b1000, 32'h00000300, 32'h00000000, 0, 1'b0, 32'h00000000, 32'h00000000, 0, 32'h00000000, 32'h00000000, 4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1, 0};
    vecs[12] = '{1'b0, 1'b0, 2'd2, 1'b0, 4'b0001, 32'h00000300, 32'h00000000, 0, 1'b0, 32'h00000000, 32'h00000000, 0, 32'h00000000, 32'h00000000, 4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1, 0};
    vecs[13] = '{1'b0, 1'b1, 2'd2, 1'b0, 4'b0010, 32'hFFFFFFFE, 32'h11223344, 0, 1'b0, 32'h00000000, 32'h00000000, 2, 32'hFFFFFFFC, 32'h00000000, 4'b1100, 4'b0011, 32'h33440000, 32'h00001122, 32'h00000000, 1'b0, 3, 2};
    vecs[14] = '{1'b1, 1'b0, 2'd0, 1'b0, 4'b0100, 32'h00000101, 32'h00000000, 1, 1'b0, 32'h0000AB00, 32'h00000000, 1, 32'h00000100, 32'h00000000, 4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 32'h000000AB, 1'b0, 3, 2};

    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_hart_sel  = '0;
    bus.in_rd_en     = 1'b0;
    bus.in_wr_en     = 1'b0;
    bus.in_addr      = '0;
    bus.in_wr_data   = '0;
    bus.in_size      = '0;
    bus.in_sign_ext  = 1'b0;
    bus.dmem_rd_ack  = 1'b0;
    bus.dmem_wr_ack  = 1'b0;
    bus.dmem_rd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_en", 64'({bus.dmem_rd_en, bus.dmem_wr_en}), 64'd0);
    checkOutput("reset_addr", 64'(bus.dmem_addr), 64'd0);
    checkOutput("reset_data", 64'(bus.out_rd_data), 64'd0);
    checkOutput("reset_fault", 64'(bus.out_fault), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Split load interrupted by reset while its second beat waits for an ack.
    bus.in_valid    = 1'b1;
    bus.in_hart_sel = 4'b0001;
    bus.in_rd_en    = 1'b1;
    bus.in_wr_en    = 1'b0;
    bus.in_addr     = 32'h000001FE;
    bus.in_size     = 2'd2;
    bus.in_sign_ext = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checkOutput("rst_beat0_en", 64'(bus.dmem_rd_en), 64'd1);
    bus.dmem_rd_ack  = 1'b1;
    bus.dmem_rd_data = 32'h55667788;
    @(posedge clk); #1;
    bus.dmem_rd_ack = 1'b0;
    checkOutput("rst_beat1_addr", 64'(bus.dmem_addr), 64'h200);
    @(posedge clk); #1;
    checkOutput("rst_beat1_en", 64'(bus.dmem_rd_en), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_en", 64'(bus.dmem_rd_en), 64'd0);
    checkOutput("rst_async_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("rst_after_valid%0d", k), 64'(bus.out_valid), 64'd0);
      checkOutput($sformatf("rst_after_ready%0d", k), 64'(bus.in_ready), 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/memrw_split.md
Name: memrw_split

Overview:
Multi-cycle, registered load/store stage for the multi-hart (barrel) integer pipeline. It sits between execute and writeback and replaces the single-cycle memory stage.
- Accepts one access per handshake and holds the dmem request until it is acknowledged.
- Splits misaligned accesses that cross a word boundary into two word-aligned beats.
- Aligns and sign/zero-extends load data.
- Reports bus timeouts as faults tagged with the issuing hart.

Parameters:
- NUM_HART, 4, number of harts; one-hot hart select width
- REG_WIDTH, 32, register/bus width in bits; 32 or 64
- MEM_ADDR_WIDTH, 32, byte address width
- WAIT_LIMIT, 255, maximum wait cycles per beat before a fault is declared; must be ≥1
- BYTES_PER_REG (derived), REG_WIDTH/8
- OFF_W (derived), $clog2(BYTES_PER_REG)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  access offered
- in_ready  out  1  stage can accept an access
- in_hart_sel  in  NUM_HART  one-hot issuing hart
- in_rd_en  in  1  load
- in_wr_en  in  1  store
- in_addr  in  MEM_ADDR_WIDTH  byte address
- in_wr_data  in  REG_WIDTH  store data, right-aligned
- in_size  in  2  access size: 0=B, 1=H, 2=W, 3=D (D legal only when REG_WIDTH=64)
- in_sign_ext  in  1  sign-extend load result
- dmem_addr  out  MEM_ADDR_WIDTH  word-aligned address
- dmem_rd_en  out  1  read request, level, held until ack
- dmem_wr_en  out  1  write request, level, held until ack
- dmem_wr_data  out  REG_WIDTH  lane-shifted store data
- dmem_wr_ben  out  BYTES_PER_REG  byte enables
- dmem_rd_ack  in  1  read data valid this cycle
- dmem_rd_data  in  REG_WIDTH  read word
- dmem_wr_ack  in  1  write accepted this cycle
- out_valid  out  1  result valid, one-cycle pulse
- out_hart_sel  out  NUM_HART  hart of the result
- out_rd_data  out  REG_WIDTH  aligned, extended load data; 0 for stores and faults
- out_fault  out  1  access fault: timeout or illegal request

Behaviour:
- FSM states: IDLE, BEAT0, BEAT1, DONE.
- Reset: state=IDLE; all outputs 0 except in_ready=1. dmem enables drop asynchronously with rst. An in-flight access is discarded and no out_valid is produced.
- in_ready=1 only in IDLE. An access is accepted when in_valid & in_ready. On acceptance, register the access and compute:
  - off = in_addr[OFF_W-1:0]
  - n = 1<<in_size
  - split = (off + n > BYTES_PER_REG)
- Transitions from IDLE on accept:
  - Illegal request (rd&wr, or size 3 with REG_WIDTH=32): go to DONE with fault=1.
  - Neither rd nor wr: go to DONE with fault=0; out_valid appears 1 cycle after accept.
  - Otherwise: go to BEAT0.
- BEAT0 drive (outputs are registered and stable for the whole beat):
  - dmem_addr = {addr[MSB:OFF_W], 0}
  - dmem_wr_ben = (2^n - 1) << off, truncated to BYTES_PER_REG
  - dmem_wr_data = wr_data << 8*off
- BEAT1 drive:
  - dmem_addr = BEAT0 address + BYTES_PER_REG, wrapping modulo 2^MEM_ADDR_WIDTH
  - dmem_wr_ben = (2^n - 1) >> (BYTES_PER_REG - off)
  - dmem_wr_data = wr_data >> 8*(BYTES_PER_REG - off)
- Ack rules:
  - A beat completes on the matching ack only: rd_ack for loads, wr_ack for stores. A non-matching ack is ignored.
  - An ack in the same cycle the beat is first driven is legal.
  - On a load ack, capture dmem_rd_data as lo (BEAT0) or hi (BEAT1).
  - After the BEAT0 ack: go to BEAT1 if split, else go to DONE.
  - After the BEAT1 ack: go to DONE.
- Timeout:
  - A wait counter resets at each beat start and increments every unacked cycle.
  - When it reaches WAIT_LIMIT with no ack, deassert the enable, set fault=1, and go to DONE.
  - An ack arriving in the same cycle the limit is reached wins: no fault.
- DONE: out_valid=1 for exactly one cycle with registered hart/data/fault, then go to IDLE (in_ready=1 the following cycle).
- Load data:
  - Form {hi,lo} >> 8*off (hi=0 when not split).
  - Truncate to n bytes.
  - Sign-extend from bit 8n-1 if sign_ext, else zero-extend.
- Latency (accept at cycle T, acks immediate):
  - out_valid at T+2 for an unsplit access
  - out_valid at T+3 for a split access
- Throughput: one access per 3 cycles minimum. No pipelining of multiple accesses.

Test Plan:
1. Reset mid-operation: rst asserted during BEAT1 wait -> dmem_rd_en=0 in the same cycle; after release in_ready=1, no out_valid.
2. Aligned load: REG_WIDTH=32, LW addr 0x100, rd_data 0x80FF1234 acked immediately -> one beat at dmem_addr 0x100; out_valid at T+2 with out_rd_data 0x80FF1234, fault=0.
3. Signed byte load: LB addr 0x103, sign_ext=1, rd_data 0x80FF1234 -> dmem_addr 0x100, out_rd_data 0xFFFFFF80; with sign_ext=0 -> 0x00000080.
4. Split store: SW addr 0x106, wr_data 0xAABBCCDD, acks after 2 cycles each:
   - beat0: addr 0x104, ben 4'b1100, data 0xCCDD0000
   - beat1: addr 0x108, ben 4'b0011, data 0x0000AABB
   - out_valid once, fault=0
5. Split load: LH addr 0x1FF, beat0 data 0x11xxxxxx, beat1 data 0xxxxxxx22 -> out_rd_data 0x00002211 (zero-extended), dmem_addr sequence 0x1FC then 0x200.
6. Timeout and illegal request:
   - WAIT_LIMIT=4, load with no ack -> rd_en high exactly 4 cycles, then out_valid with fault=1, rd_data=0.
   - rd&wr both set -> no dmem request; out_valid at T+1 with fault=1.
